host_bus_master: RTL and testbench
==================================

HOST_BUS_MASTER -- requirements
Module: host_bus_master

Interface
REQ-001 Parameter STROBE_CYCLES, default 2, number of clocks IOR_n/IOW_n is held active (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-004 cmd_valid  input  1  host request to perform one I/O cycle.
REQ-005 cmd_ready  output  1  high only in IDLE with HRQ low; transfer accepted when cmd_valid && cmd_ready at an edge.
REQ-006 cmd_write  input  1  1 = I/O write, 0 = I/O read.
REQ-007 cmd_addr  input  16  I/O address; DMA registers occupy 0..7.
REQ-008 cmd_data  input  8  write data.
REQ-009 rsp_valid  output  1  one-cycle pulse: read completed.
REQ-010 rsp_data  output  8  read data; valid while rsp_valid, held until the next read completes.
REQ-011 address_bus  inout  16  driven only in SETUP/STROBE/RECOVER, else 16'hzzzz.
REQ-012 data_bus  inout  8  driven only during write SETUP/STROBE/RECOVER, else 8'hzz.
REQ-013 IOR_n  output  1  active-low read strobe.
REQ-014 IOW_n  output  1  active-low write strobe.
REQ-015 HRQ  input  1  DMA hold request.
REQ-016 HLDA  output  1  hold acknowledge; buses released while high.

Function
REQ-017 FSM states IDLE, SETUP, STROBE, RECOVER, HOLD; encoding free.
REQ-018 IDLE: HRQ high -> HOLD (HRQ wins over simultaneous cmd_valid; command stays pending, not accepted); else accepted command -> SETUP, latching cmd_write/cmd_addr/cmd_data.
REQ-019 SETUP lasts 1 cycle: address_bus = latched address, data_bus = latched data on write, both strobes high.
REQ-020 STROBE lasts exactly STROBE_CYCLES cycles, via 4-bit counter: IOR_n low on read, IOW_n low on write, never both low.
REQ-021 Read data sampled from data_bus at the edge ending the last STROBE cycle.
REQ-022 RECOVER lasts 1 cycle: strobes high, address (and write data) still driven; rsp_valid=1 there for reads only; then -> IDLE.
REQ-023 Transfer length = 2 + STROBE_CYCLES cycles from acceptance edge to IDLE; cmd_ready low throughout.
REQ-024 HRQ rising during SETUP/STROBE/RECOVER does not abort; HOLD entered from IDLE the following cycle if HRQ still high.
REQ-025 HOLD: HLDA=1, address_bus/data_bus high-Z, strobes high, cmd_ready=0; HLDA rises the cycle after HOLD entry edge.
REQ-026 HOLD -> IDLE at the first edge HRQ sampled low; HLDA=0 in that same following cycle; one IDLE cycle before any new acceptance.
REQ-027 Output registers: HLDA, IOR_n, IOW_n, rsp_valid registered; bus enables decoded from registered state only (no glitch to drive while HLDA=1).
REQ-028 Never drive address_bus or data_bus in the same cycle HLDA=1.

Reset
REQ-029 Reset low at an edge -> IDLE next cycle, from any state, mid-strobe included.
REQ-030 Reset values: HLDA=0, IOR_n=1, IOW_n=1, rsp_valid=0, rsp_data=8'h00, cmd_ready=0 while Reset low, buses high-Z, strobe counter 0.
REQ-031 In-flight command discarded on reset; no rsp_valid generated for it.

Verification
REQ-032 Write: cmd_addr=16'h0005, cmd_data=8'hA5, STROBE_CYCLES=2 -> address 0005 and data A5 driven 4 cycles, IOW_n low exactly 2 cycles, IOR_n stays high.
REQ-033 Read: cmd_addr=16'h0003, bench drives data_bus=8'h3C during strobe -> IOR_n low 2 cycles, rsp_valid one pulse, rsp_data=8'h3C, data_bus never driven by DUT.
REQ-034 HRQ and cmd_valid rise same cycle in IDLE -> HLDA=1 next cycle, buses Z, cmd_ready=0; HRQ drops -> HLDA=0 next cycle, command accepted one IDLE cycle later.
REQ-035 HRQ asserted during STROBE of a write -> transfer completes unchanged, HLDA rises only after RECOVER+IDLE; no cycle with HLDA=1 and bus driven.
REQ-036 Reset low during second STROBE cycle of a read -> next cycle IOR_n=1, buses Z, rsp_valid never pulses, rsp_data=8'h00.
REQ-037 STROBE_CYCLES=1 and 15 regression: strobe width equals parameter, total transfer 3 and 17 cycles.

Source files
------------

// File: rtl/host_bus_master.sv
// host_bus_master
//   Host-side I/O cycle engine with DMA hold arbitration. A host command
//   (read or write of one byte at a 16-bit I/O address) is turned into a
//   SETUP / STROBE / RECOVER bus cycle. While a DMA controller requests the
//   bus (HRQ), the engine parks in HOLD with HLDA high and its bus drivers off.
//
// Ports
//   clk          single clock, rising edge
//   Reset        synchronous, active-low
//   cmd_valid    host request for one I/O cycle
//   cmd_ready    high only in IDLE while HRQ is low (and not in reset)
//   cmd_write    1 = I/O write, 0 = I/O read
//   cmd_addr     I/O address
//   cmd_data     write data
//   rsp_valid    one-cycle pulse when a read completes
//   rsp_data     read data, held until the next read completes
//   address_bus  tri-state address, driven in SETUP/STROBE/RECOVER
//   data_bus     tri-state data, driven in SETUP/STROBE/RECOVER of writes
//   IOR_n/IOW_n  active-low read / write strobes (registered)
//   HRQ          DMA hold request
//   HLDA         hold acknowledge (registered)
//   state_dbg    current FSM state, for observation only
//
// Handshake: a command transfers at a rising edge where cmd_valid && cmd_ready.
// cmd_valid may be held across HOLD; the command stays pending until accepted.

module host_bus_master #(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  inout  wire  [15:0] address_bus,
  inout  wire  [7:0]  data_bus,
  output logic        IOR_n,
  output logic        IOW_n,
  input  logic        HRQ,
  output logic        HLDA,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_RECOVER = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  // Counter is loaded with the number of remaining STROBE cycles minus one.
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        addr_en;
  logic        data_en;

  // HRQ is given priority over a simultaneous command in IDLE.
  assign cmd_ready = (state_q == S_IDLE) && !HRQ && Reset;
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (HRQ) begin
          state_d = S_HOLD;
        end else if (cmd_valid) begin
          state_d = S_SETUP;
          wr_d    = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_data;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = STROBE_LAST;
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RECOVER;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RECOVER: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      S_HOLD: begin
        if (!HRQ) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Strobes, HLDA and rsp_valid are registered from the next state so they
  // line up with the state they belong to without combinational glitches.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      HLDA      <= 1'b0;
      IOR_n     <= 1'b1;
      IOW_n     <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      HLDA      <= (state_d == S_HOLD);
      IOR_n     <= !((state_d == S_STROBE) && !wr_d);
      IOW_n     <= !((state_d == S_STROBE) && wr_d);
      rsp_valid <= (state_d == S_RECOVER) && !wr_d;
      // Read data captured at the edge that ends the last STROBE cycle.
      if ((state_q == S_STROBE) && (state_d == S_RECOVER) && !wr_q)
        rsp_data <= data_bus;
    end
  end

  // Enables depend on the registered state only; HOLD never enables them,
  // so the buses are always released while HLDA is high.
  assign addr_en = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                   (state_q == S_RECOVER);
  assign data_en = addr_en && wr_q;

  assign address_bus = addr_en ? addr_q  : 16'hzzzz;
  assign data_bus    = data_en ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_host_bus_master.sv
module tb_host_bus_master;

  localparam int N = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic Reset;

  // ---------------- main DUT (STROBE_CYCLES = 2) ----------------
  logic        cmd_valid, cmd_write, HRQ;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        cmd_ready, rsp_valid, IOR_n, IOW_n, HLDA;
  logic [7:0]  rsp_data;
  logic [2:0]  state_dbg;
  wire  [15:0] address_bus;
  wire  [7:0]  data_bus;
  logic [7:0]  dev_data;

  // Released buses read back as all ones.
  pullup pu_addr (address_bus);
  pullup pu_data (data_bus);
  // Peripheral answers reads while the read strobe is low.
  assign data_bus = !IOR_n ? dev_data : 8'hzz;

  host_bus_master #(.STROBE_CYCLES(N)) dut (
    .clk(clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .address_bus(address_bus),
    .data_bus(data_bus), .IOR_n(IOR_n), .IOW_n(IOW_n), .HRQ(HRQ), .HLDA(HLDA),
    .state_dbg(state_dbg)
  );

  // ---------------- STROBE_CYCLES = 1 and 15 instances ----------------
  logic        sm_valid, sm_write, sm_hrq;
  logic [15:0] sm_addr;
  logic [7:0]  sm_data;
  logic        a_ready, a_rv, a_ior, a_iow, a_hlda;
  logic        b_ready, b_rv, b_ior, b_iow, b_hlda;
  logic [7:0]  a_rd, b_rd;
  logic [2:0]  a_st, b_st;
  wire  [15:0] a_ab, b_ab;
  wire  [7:0]  a_db, b_db;
  assign a_db = !a_ior ? 8'h5A : 8'hzz;
  assign b_db = !b_ior ? 8'hC6 : 8'hzz;

  host_bus_master #(.STROBE_CYCLES(1)) dut_n1 (
    .clk(clk), .Reset(Reset), .cmd_valid(sm_valid), .cmd_ready(a_ready),
    .cmd_write(sm_write), .cmd_addr(sm_addr), .cmd_data(sm_data),
    .rsp_valid(a_rv), .rsp_data(a_rd), .address_bus(a_ab), .data_bus(a_db),
    .IOR_n(a_ior), .IOW_n(a_iow), .HRQ(sm_hrq), .HLDA(a_hlda), .state_dbg(a_st)
  );

  host_bus_master #(.STROBE_CYCLES(15)) dut_n15 (
    .clk(clk), .Reset(Reset), .cmd_valid(sm_valid), .cmd_ready(b_ready),
    .cmd_write(sm_write), .cmd_addr(sm_addr), .cmd_data(sm_data),
    .rsp_valid(b_rv), .rsp_data(b_rd), .address_bus(b_ab), .data_bus(b_db),
    .IOR_n(b_ior), .IOW_n(b_iow), .HRQ(sm_hrq), .HLDA(b_hlda), .state_dbg(b_st)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_rsp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver / monitor for one transfer ----------------
  int m_len, m_iow, m_ior, m_both, m_rsp, m_addr_err, m_data_err, m_hlda;
  logic [7:0] m_rsp_data;
  bit m_timeout;

  task automatic run_xfer(input bit wr, input logic [15:0] addr,
                          input logic [7:0] wdata, input logic [7:0] ddata);
    int waited;
    int k;
    dev_data  = ddata;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_data  = wdata;
    cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    m_len = 0; m_iow = 0; m_ior = 0; m_both = 0; m_rsp = 0;
    m_addr_err = 0; m_data_err = 0; m_hlda = 0; m_rsp_data = 8'h00;
    m_timeout = 1'b0;
    if (!cmd_ready) begin
      m_timeout = 1'b1;
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the inputs after acceptance: the DUT must use latched values.
    cmd_valid = 1'b0;
    cmd_addr  = 16'($urandom);
    cmd_data  = 8'($urandom);
    cmd_write = 1'($urandom);
    k = 0;
    while (1) begin
      @(negedge clk);
      k++;
      if (cmd_ready) break;
      if (k > 40) begin
        m_timeout = 1'b1;
        break;
      end
      m_len++;
      if (!IOW_n) m_iow++;
      if (!IOR_n) m_ior++;
      if (!IOW_n && !IOR_n) m_both++;
      if (rsp_valid) begin
        m_rsp++;
        m_rsp_data = rsp_data;
      end
      if (HLDA) m_hlda++;
      if (address_bus !== addr) m_addr_err++;
      if (wr && data_bus !== wdata) m_data_err++;
      if (!wr && IOR_n && data_bus !== 8'hFF) m_data_err++;
    end
  endtask

  task automatic check_xfer(input string tag, input bit wr, input int e_iow,
                            input int e_ior, input int e_rsp, input logic [7:0] e_rd,
                            input int e_len);
    chk({tag, "_timeout"}, 32'(m_timeout), 0);
    chk({tag, "_len"}, m_len, e_len);
    chk({tag, "_iow_width"}, m_iow, e_iow);
    chk({tag, "_ior_width"}, m_ior, e_ior);
    chk({tag, "_both_low"}, m_both, 0);
    chk({tag, "_rsp_pulses"}, m_rsp, e_rsp);
    chk({tag, "_addr_err"}, m_addr_err, 0);
    chk({tag, "_data_err"}, m_data_err, 0);
    chk({tag, "_hlda"}, m_hlda, 0);
    chk({tag, "_rsp_data_held"}, rsp_data, e_rd);
    chk({tag, "_addr_released"}, address_bus, 16'hFFFF);
    chk({tag, "_data_released"}, data_bus, 8'hFF);
    if (!wr && m_rsp == 1) begin
      if (exp_q.size() > 0) chk({tag, "_rsp_value"}, m_rsp_data, exp_q.pop_front());
      else chk({tag, "_rsp_unexpected"}, 1, 0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  dev;
    int          e_iow;
    int          e_ior;
    int          e_rsp;
    logic [7:0]  e_rsp_data;
    int          e_len;
  } vec_t;

  vec_t vecs[4];

  // ---------------- small-instance sequence ----------------
  task automatic run_small(input bit wr);
    int waited;
    int la, lb, wa, wb, ra, rb;
    bit da, db;
    sm_write = wr;
    sm_addr  = 16'h0004;
    sm_data  = 8'h77;
    sm_valid = 1'b1;
    waited = 0;
    while (!(a_ready && b_ready) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("small_accept", 32'(a_ready && b_ready), 1);
    @(posedge clk);
    #1 sm_valid = 1'b0;
    la = 0; lb = 0; wa = 0; wb = 0; ra = 0; rb = 0; da = 0; db = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!da) begin
        if (a_ready) da = 1;
        else begin
          la++;
          if (!(wr ? a_iow : a_ior)) wa++;
          if (a_rv) ra++;
        end
      end
      if (!db) begin
        if (b_ready) db = 1;
        else begin
          lb++;
          if (!(wr ? b_iow : b_ior)) wb++;
          if (b_rv) rb++;
        end
      end
      if (da && db) break;
    end
    chk("n1_done", 32'(da), 1);
    chk("n15_done", 32'(db), 1);
    chk("n1_len", la, 3);
    chk("n15_len", lb, 17);
    chk("n1_strobe", wa, 1);
    chk("n15_strobe", wb, 15);
    chk("n1_rsp", ra, wr ? 0 : 1);
    chk("n15_rsp", rb, wr ? 0 : 1);
    if (!wr) begin
      chk("n1_rdata", a_rd, 8'h5A);
      chk("n15_rdata", b_rd, 8'hC6);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // ---------------- main test ----------------
  initial begin
    int pulses;
    bit wr;
    logic [15:0] a;
    logic [7:0] d, dv;

    vecs[0] = '{1'b1, 16'h0005, 8'hA5, 8'h00, N, 0, 0, 8'h00, N + 2};
    vecs[1] = '{1'b0, 16'h0003, 8'h00, 8'h3C, 0, N, 1, 8'h3C, N + 2};
    vecs[2] = '{1'b1, 16'h0007, 8'h5A, 8'h00, N, 0, 0, 8'h3C, N + 2};
    vecs[3] = '{1'b0, 16'h0000, 8'h00, 8'hC3, 0, N, 1, 8'hC3, N + 2};

    Reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_data = 8'h0;
    HRQ = 1'b0; dev_data = 8'h00;
    sm_valid = 1'b0; sm_write = 1'b0; sm_addr = 16'h0; sm_data = 8'h0; sm_hrq = 1'b0;

    // Reset values, sampled while Reset is still low.
    repeat (3) @(negedge clk);
    chk("rst_hlda", HLDA, 0);
    chk("rst_ior", IOR_n, 1);
    chk("rst_iow", IOW_n, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_addr_z", address_bus, 16'hFFFF);
    chk("rst_data_z", data_bus, 8'hFF);
    Reset = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);

    // Parameter regression on the 1- and 15-cycle instances.
    run_small(1'b1);
    run_small(1'b0);

    // Table-driven directed transfers.
    model_rsp = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (!vecs[i].wr) exp_q.push_back(vecs[i].dev);
      run_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].dev);
      check_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].e_iow, vecs[i].e_ior,
                 vecs[i].e_rsp, vecs[i].e_rsp_data, vecs[i].e_len);
    end
    model_rsp = 8'hC3;

    // Randomized transfers against the reference model.
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      wr = 1'($urandom_range(0, 1));
      a  = 16'($urandom_range(0, 16'hFFFE));
      d  = 8'($urandom_range(0, 8'hFE));
      dv = 8'($urandom_range(0, 255));
      if (!wr) begin
        exp_q.push_back(dv);
        model_rsp = dv;
      end
      run_xfer(wr, a, d, dv);
      check_xfer($sformatf("rnd%0d", i), wr, wr ? N : 0, wr ? 0 : N,
                 wr ? 0 : 1, model_rsp, N + 2);
    end
    chk("scoreboard_empty", exp_q.size(), 0);

    // HRQ and cmd_valid rise together in IDLE.
    cmd_write = 1'b1; cmd_addr = 16'h0002; cmd_data = 8'h11; cmd_valid = 1'b1; HRQ = 1'b1;
    #1 chk("hrq_ready_low", cmd_ready, 0);
    @(negedge clk);
    chk("hold_hlda", HLDA, 1);
    chk("hold_addr_z", address_bus, 16'hFFFF);
    chk("hold_data_z", data_bus, 8'hFF);
    chk("hold_ready", cmd_ready, 0);
    chk("hold_iow", IOW_n, 1);
    @(negedge clk);
    chk("hold_hlda_2", HLDA, 1);
    HRQ = 1'b0;
    @(negedge clk);
    chk("unhold_hlda", HLDA, 0);
    chk("unhold_ready", cmd_ready, 1);
    chk("unhold_addr_z", address_bus, 16'hFFFF);
    @(negedge clk);
    chk("pending_accept_addr", address_bus, 16'h0002);
    chk("pending_accept_data", data_bus, 8'h11);
    chk("pending_accept_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    repeat (N + 2) @(negedge clk);
    chk("pending_done_ready", cmd_ready, 1);

    // HRQ raised during STROBE of a write.
    cmd_write = 1'b1; cmd_addr = 16'h0006; cmd_data = 8'h3A; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("hs_setup_iow", IOW_n, 1);
    chk("hs_setup_addr", address_bus, 16'h0006);
    @(negedge clk);
    chk("hs_strobe1_iow", IOW_n, 0);
    HRQ = 1'b1;
    @(negedge clk);
    chk("hs_strobe2_iow", IOW_n, 0);
    chk("hs_strobe2_hlda", HLDA, 0);
    chk("hs_strobe2_data", data_bus, 8'h3A);
    @(negedge clk);
    chk("hs_recover_iow", IOW_n, 1);
    chk("hs_recover_hlda", HLDA, 0);
    chk("hs_recover_addr", address_bus, 16'h0006);
    @(negedge clk);
    chk("hs_idle_hlda", HLDA, 0);
    chk("hs_idle_addr_z", address_bus, 16'hFFFF);
    chk("hs_idle_ready", cmd_ready, 0);
    @(negedge clk);
    chk("hs_hold_hlda", HLDA, 1);
    chk("hs_hold_addr_z", address_bus, 16'hFFFF);
    chk("hs_hold_data_z", data_bus, 8'hFF);
    HRQ = 1'b0;
    @(negedge clk);
    chk("hs_release_hlda", HLDA, 0);
    chk("hs_release_ready", cmd_ready, 1);

    // Reset during the second STROBE cycle of a read.
    dev_data = 8'h3C;
    cmd_write = 1'b0; cmd_addr = 16'h0003; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rr_strobe1_ior", IOR_n, 0);
    @(negedge clk);
    chk("rr_strobe2_ior", IOR_n, 0);
    Reset = 1'b0;
    @(negedge clk);
    chk("rr_ior", IOR_n, 1);
    chk("rr_addr_z", address_bus, 16'hFFFF);
    chk("rr_data_z", data_bus, 8'hFF);
    chk("rr_rsp_valid", rsp_valid, 0);
    chk("rr_rsp_data", rsp_data, 8'h00);
    chk("rr_ready", cmd_ready, 0);
    Reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("rr_no_rsp", pulses, 0);
    chk("rr_rsp_data_after", rsp_data, 8'h00);
    chk("rr_idle_ready", cmd_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
